// File: rtl/mult_secuencial.sv
// Sequential shift-add multiplier, N iterations per product.
// Define MULT_SECUENCIAL_SIGNED_EN for two's complement operands.
module mult_secuencial #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p,
  output logic [N-1:0]   c,
  output logic           co
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [N-1:0]     mc_q;
  logic [N:0]       hi_q;
  logic [N-1:0]     lo_q;
  logic [CW-1:0]    cnt_q;
  logic [2*N-1:0]   p_q;
  logic             co_q;

  logic [N:0]       sum;
  logic [N:0]       hi_d;
  logic [N-1:0]     lo_d;
  logic [2*N-1:0]   prod;
  logic [2*N-1:0]   p_d;
  logic             co_d;
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             last;

`ifdef MULT_SECUENCIAL_SIGNED_EN
  logic             sign_q;
  logic [N:0]       top;
`endif

  // Sum is N+1 bits wide; hi_q stays below 2^N so the carry is kept.
  always_comb begin
    sum  = lo_q[0] ? (hi_q + {1'b0, mc_q}) : hi_q;
    hi_d = {1'b0, sum[N:1]};
    lo_d = {sum[0], lo_q[N-1:1]};
    prod = {hi_d[N-1:0], lo_d};
    last = (cnt_q == CW'(N - 1));
`ifdef MULT_SECUENCIAL_SIGNED_EN
    a_in = a[N-1] ? -a : a;
    b_in = b[N-1] ? -b : b;
    p_d  = sign_q ? -prod : prod;
    top  = p_d[2*N-1:N-1];
    co_d = !((&top) || (~|top));
`else
    a_in = a;
    b_in = b;
    p_d  = prod;
    co_d = |prod[2*N-1:N];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mc_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      co_q    <= 1'b0;
`ifdef MULT_SECUENCIAL_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mc_q    <= a_in;
            lo_q    <= b_in;
            hi_q    <= '0;
            cnt_q   <= '0;
`ifdef MULT_SECUENCIAL_SIGNED_EN
            sign_q  <= a[N-1] ^ b[N-1];
`endif
            state_q <= CALC;
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            p_q     <= p_d;
            co_q    <= co_d;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign p    = p_q;
  assign c    = p_q[N-1:0];
  assign co   = co_q;

endmodule

// File: tb/tb_mult_secuencial.sv
// Bench for mult_secuencial: N=4 and N=8 instances against an
// arithmetic reference model, directed and random operands.
module tb_mult_secuencial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, co4;
  logic       busy8, done8, co8;
  logic [7:0] p4, c8;
  logic [3:0] c4;
  logic [15:0] p8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_secuencial #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4), .c(c4), .co(co4)
  );

  mult_secuencial #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8), .c(c8), .co(co8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Product and overflow from plain integer arithmetic.
  function automatic void model(input int n, input longint x,
                                input longint y, output longint pp,
                                output logic ov);
    longint s, sx, sy;
`ifdef MULT_SECUENCIAL_SIGNED_EN
    sx = (x >= (64'sd1 << (n - 1))) ? x - (64'sd1 << n) : x;
    sy = (y >= (64'sd1 << (n - 1))) ? y - (64'sd1 << n) : y;
    s  = sx * sy;
    ov = (s < -(64'sd1 << (n - 1))) || (s > (64'sd1 << (n - 1)) - 1);
`else
    sx = x;
    sy = y;
    s  = sx * sy;
    ov = (s >= (64'sd1 << n));
`endif
    pp = s & ((64'sd1 << (2 * n)) - 1);
  endfunction

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    longint ep;
    logic   eco;
    model(4, longint'(x), longint'(y), ep, eco);
    @(negedge clk);
    start4 = 1'b1; a4 = x; b4 = y;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    chk("busy_t0", 64'(busy4), 64'd1);
    chk("done_t0", 64'(done4), 64'd0);
    for (int i = 1; i < 4; i++) begin
      if (i == 2) start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      chk("busy_calc", 64'(busy4), 64'd1);
      chk("done_calc", 64'(done4), 64'd0);
    end
    @(posedge clk); #1;
    chk("busy_done", 64'(busy4), 64'd0);
    chk("done_pulse", 64'(done4), 64'd1);
    chk("p4", 64'(p4), 64'(ep));
    chk("c4", 64'(c4), 64'(ep[3:0]));
    chk("co4", 64'(co4), 64'(eco));
    @(posedge clk); #1;
    chk("done_low", 64'(done4), 64'd0);
    chk("busy_idle", 64'(busy4), 64'd0);
    chk("p4_hold", 64'(p4), 64'(ep));
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    longint ep;
    logic   eco;
    int     n;
    model(8, longint'(x), longint'(y), ep, eco);
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 1;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat8", 64'(n), 64'd9);
    chk("p8", 64'(p8), 64'(ep));
    chk("c8", 64'(c8), 64'(ep[7:0]));
    chk("co8", 64'(co8), 64'(eco));
    @(posedge clk); #1;
  endtask

  initial begin
    int seen, first, second, cnt;
    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_done", 64'(done4), 64'd0);
    chk("rst_p", 64'(p4), 64'd0);
    chk("rst_c", 64'(c4), 64'd0);
    chk("rst_co", 64'(co4), 64'd0);
    chk("rst_p8", 64'(p8), 64'd0);
    rst = 1'b0;
    op4(4'b1101, 4'b1010);
`ifndef MULT_SECUENCIAL_SIGNED_EN
    chk("vec_1101x1010", 64'(p4), 64'h82);
`endif
    op4(4'b1000, 4'b0010);
    op4(4'b1001, 4'b0011);
    op4(4'b1111, 4'b0011);
    op4(4'b0011, 4'b0001);
    op4(4'b1000, 4'b1111);
    op4(4'b0000, 4'b1111);
    op4(4'b1111, 4'b1111);
    for (int k = 0; k < 20; k++) op4(4'($urandom), 4'($urandom));

    // Reset two edges into a calculation.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd9;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy4), 64'd0);
    chk("abort_done", 64'(done4), 64'd0);
    chk("abort_p", 64'(p4), 64'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // Start held high: one result every N+2 cycles.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
    seen = 0; first = 0; second = 0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(posedge clk); #1;
      if (done4) begin
        seen++;
        if (seen == 1) first = cyc;
        if (seen == 2) second = cyc;
        chk("stream_p", 64'(p4), 64'd15);
      end
    end
    start4 = 1'b0;
    chk("stream_cnt", 64'(seen), 64'd3);
    chk("stream_first", 64'(first), 64'd5);
    chk("stream_period", 64'(second - first), 64'd6);
    repeat (2) @(posedge clk);

    op8(8'hFF, 8'hFF);
    op8(8'h80, 8'h02);
    op8(8'h00, 8'h7F);
    for (int k = 0; k < 6; k++) op8(8'($urandom), 8'($urandom));

    cnt = 0;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_secuencial.md
MULT_SECUENCIAL -- requirements
Module: mult_secuencial

Interface
REQ-001 SHALL have parameter: N, 4, operand width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request new multiplication; sampled only in IDLE.
REQ-005 SHALL have port: a  input  N  multiplicand, latched on accepted start.
REQ-006 SHALL have port: b  input  N  multiplier, latched on accepted start.
REQ-007 SHALL have port: busy  output  1  high while state is CALC.
REQ-008 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port: p  output  2N  full product.
REQ-010 SHALL have port: c  output  N  truncated product, p[N-1:0].
REQ-011 SHALL have port: co  output  1  overflow: product not representable in N bits.

Function
REQ-012 SHALL implement FSM with states IDLE, CALC, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with start=1 at edge t0, latch a and b, clear accumulator and iteration counter, and enter CALC.
REQ-014 SHALL perform one shift-add iteration per edge t0+1..t0+N (multiplier LSB selects add of multiplicand into upper accumulator half, then shift right one bit).
REQ-015 SHALL enter DONE after edge t0+N and IDLE after edge t0+N+1, with no early exit for zero operands.
REQ-016 SHALL hold busy=1 exactly while in CALC (N cycles), and done=1 exactly while in DONE (1 cycle).
REQ-017 SHALL update p, c, co only on the CALC->DONE transition and hold them stable until the next DONE.
REQ-018 SHALL ignore start while in CALC or DONE; latched operands SHALL be unaffected by changes on a/b after t0.
REQ-019 SHALL, with start held high continuously, accept a new operation in each IDLE cycle (one result per N+2 cycles).
REQ-020 SHALL, in unsigned mode, set co=1 iff p[2N-1:N] != 0.
REQ-021 SHALL compute accumulator sums at N+1 bits so no carry is lost during iteration.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, enter IDLE and clear busy, done, p, c, co, counter and accumulator to 0.
REQ-023 SHALL give rst priority over start; reset during CALC SHALL abort the operation with no done pulse.
REQ-024 SHALL accept start on the first edge with rst=0.

Configuration
REQ-025 SHALL support macro MULT_SECUENCIAL_SIGNED_EN.
REQ-026 SHALL, with MULT_SECUENCIAL_SIGNED_EN defined, treat a, b as two's complement: multiply magnitudes, negate p at CALC->DONE when signs differ, latency unchanged.
REQ-027 SHALL, with MULT_SECUENCIAL_SIGNED_EN defined, set co=1 iff signed p lies outside [-2^(N-1), 2^(N-1)-1]; -2^(N-1) magnitude handled at N+1 bits.
REQ-028 SHALL, without the macro, be purely unsigned with no sign logic present.

Verification
REQ-029 SHALL verify N=4 unsigned: a=1101, b=1010 -> after N+1 edges done=1, p=10000010, c=0010, co=1.
REQ-030 SHALL verify N=4 unsigned vectors: 1000*0010 -> c=0000 co=1; 1001*0011 -> c=1011 co=1; 1111*0011 -> c=1101 co=1; 0011*0001 -> c=0011 co=0.
REQ-031 SHALL verify timing: start at t0 -> busy high edges t0..t0+N-1 only, done high for exactly one cycle after t0+N; start pulsed during CALC -> no effect on result.
REQ-032 SHALL verify reset mid-CALC: rst at t0+2 -> next cycle busy=0, done=0, p=0, no done pulse follows.
REQ-033 SHALL verify signed build N=4: 1111*0011 -> p=11111101, c=1101, co=0; 1000*1111 -> p=00001000, co=1.
REQ-034 SHALL verify N=8 unsigned: 0xFF*0xFF -> p=0xFE01, c=0x01, co=1, done after 9 edges.
